// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter
//   Circular byte buffer shared by the USB RX path, the USB TX path and the
//   host register interface. It owns the storage, the read/write pointers and
//   the occupancy count, and grants at most one memory access per cycle.
//   Grant priority: flush > RX store > TX get > host (store/get round-robin).
//
// Optional feature (macro BUF_ALMOST_THRESH_EN):
//   Adds parameter ALMOST_FULL and registered outputs almost_full/almost_empty.
//
// Ports:
//   clk, n_rst                              clock, async active-low reset
//   flush                                   empty the buffer (pulse)
//   store_rx_packet_data, rx_packet_data    RX byte strobe + data (never stalls)
//   tx_get_req / tx_get_ack                 TX read handshake (ack combinational)
//   host_store_req/_data / host_store_ack   host write handshake
//   host_get_req / host_get_ack             host read handshake
//   rdata, rdata_valid, rdata_to_tx         registered read data and its owner
//   buffer_occupancy                        bytes stored, 0..DEPTH
//   overflow, underflow, clear_errors       sticky error flags and their clear
//   almost_full, almost_empty               threshold flags (optional)
module usb_buffer_arbiter #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
`ifdef BUF_ALMOST_THRESH_EN
    ,
    parameter int ALMOST_FULL = DEPTH - 4
`endif
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              store_rx_packet_data,
    input  logic [7:0]        rx_packet_data,
    input  logic              tx_get_req,
    output logic              tx_get_ack,
    input  logic              host_store_req,
    input  logic [7:0]        host_store_data,
    output logic              host_store_ack,
    input  logic              host_get_req,
    output logic              host_get_ack,
    output logic [7:0]        rdata,
    output logic              rdata_valid,
    output logic              rdata_to_tx,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              overflow,
    output logic              underflow,
`ifdef BUF_ALMOST_THRESH_EN
    output logic              almost_full,
    output logic              almost_empty,
`endif
    input  logic              clear_errors
);

    localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_occ;
    logic [7:0]        r_rdata;
    logic              r_rdata_valid;
    logic              r_rdata_to_tx;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_rr_store_pri;   // 1: host store wins a host tie

    logic              w_rx_grant;
    logic              w_wr;
    logic              w_rd;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_wdata;

    assign w_full     = (r_occ == OCC_FULL);
    assign w_empty    = (r_occ == '0);
    // A flush swallows a concurrent RX byte, so the RX grant is flush-qualified.
    assign w_rx_grant = store_rx_packet_data && !flush;
    assign w_wr       = w_rx_grant || host_store_ack;
    assign w_rd       = tx_get_ack || host_get_ack;
    assign w_wdata    = w_rx_grant ? rx_packet_data : host_store_data;

    always_comb begin
        tx_get_ack     = 1'b0;
        host_store_ack = 1'b0;
        host_get_ack   = 1'b0;
        if (!flush && !store_rx_packet_data) begin
            if (tx_get_req) begin
                tx_get_ack = 1'b1;
            end else if (host_store_req && (r_rr_store_pri || !host_get_req)) begin
                host_store_ack = 1'b1;
            end else if (host_get_req) begin
                host_get_ack = 1'b1;
            end
        end
    end

    // Storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_wr && !w_full) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_occ          <= '0;
            r_rdata        <= 8'h00;
            r_rdata_valid  <= 1'b0;
            r_rdata_to_tx  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_rr_store_pri <= 1'b1;
        end else begin
            r_rdata_valid <= w_rd;
            if (w_rd) begin
                r_rdata_to_tx <= tx_get_ack;
            end

            // Grants are mutually exclusive, so write and read never coincide.
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
            end else if (w_wr) begin
                if (!w_full) begin
                    r_wptr <= r_wptr + PTR_ONE;
                    r_occ  <= r_occ + OCC_ONE;
                end
            end else if (w_rd) begin
                if (!w_empty) begin
                    r_rdata <= r_mem[r_rptr];
                    r_rptr  <= r_rptr + PTR_ONE;
                    r_occ   <= r_occ - OCC_ONE;
                end else begin
                    r_rdata <= 8'h00;
                end
            end

            // The last-served host requester loses the next tie.
            if (host_store_ack) begin
                r_rr_store_pri <= 1'b0;
            end else if (host_get_ack) begin
                r_rr_store_pri <= 1'b1;
            end

            // A same-cycle error event overrides clear_errors.
            r_overflow  <= (r_overflow  && !clear_errors) || (w_wr && w_full);
            r_underflow <= (r_underflow && !clear_errors) || (w_rd && w_empty);
        end
    end

    assign rdata            = r_rdata;
    assign rdata_valid      = r_rdata_valid;
    assign rdata_to_tx      = r_rdata_to_tx;
    assign buffer_occupancy = r_occ;
    assign overflow         = r_overflow;
    assign underflow        = r_underflow;

`ifdef BUF_ALMOST_THRESH_EN
    localparam logic [ADDR_W:0] OCC_AF = (ADDR_W+1)'(ALMOST_FULL);

    logic r_almost_full;
    logic r_almost_empty;

    // Derived from the registered count, so they trail occupancy by one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (r_occ >= OCC_AF);
            r_almost_empty <= (r_occ <= OCC_ONE);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

endmodule
